// File: rtl/id_hazard_scoreboard_if.sv
// ---------------------------------------------------------------------------
// id_hazard_scoreboard_if
// Groups the ID/EX/WB pipeline-control signals seen by the hazard scoreboard.
// The slave modport is used by the scoreboard; the master modport is used by
// the pipeline (or a bench) that drives the stage information.
// ---------------------------------------------------------------------------
interface id_hazard_scoreboard_if #(
  parameter int AW    = 5,
  parameter int CNT_W = 32
);
  // ID-stage consumer / producer information
  logic [AW-1:0]    ID_RegRs;
  logic [AW-1:0]    ID_RegRt;
  logic             ID_uses_rs;
  logic             ID_uses_rt;
  logic [AW-1:0]    ID_RegRd;
  logic             ID_MemRead;
  logic             branch_or_jalr;
  // later pipeline stages
  logic [AW-1:0]    EX_RegRd;
  logic             EX_RegWrite;
  logic [AW-1:0]    WB_RegRd;
  logic             WB_RegWrite;
  logic             mem_wait;
  logic             flush_EX;
  // hazard decisions
  logic             stall_ID;
  logic             bubble_EX;
  logic             freeze;
  logic [1:0]       haz_state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] freeze_cnt;

  modport slave (
    input  ID_RegRs, ID_RegRt, ID_uses_rs, ID_uses_rt, ID_RegRd, ID_MemRead,
           branch_or_jalr, EX_RegRd, EX_RegWrite, WB_RegRd, WB_RegWrite,
           mem_wait, flush_EX,
    output stall_ID, bubble_EX, freeze, haz_state, stall_cnt, freeze_cnt
  );

  modport master (
    output ID_RegRs, ID_RegRt, ID_uses_rs, ID_uses_rt, ID_RegRd, ID_MemRead,
           branch_or_jalr, EX_RegRd, EX_RegWrite, WB_RegRd, WB_RegWrite,
           mem_wait, flush_EX,
    input  stall_ID, bubble_EX, freeze, haz_state, stall_cnt, freeze_cnt
  );
endinterface

// File: rtl/id_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// id_hazard_scoreboard
// Decides whether an ID-stage consumer can proceed (value forwarded from
// MEM/WB) or must wait: tracks in-flight load destinations in a busy-bit
// scoreboard, detects branch/jalr dependences on the EX-stage result and
// freezes the whole pipeline while memory is not ready.
// Optional feature: define HAZ_PERF_CNT_EN to build saturating stall/freeze
// performance counters; otherwise stall_cnt/freeze_cnt are tied to zero.
// ---------------------------------------------------------------------------
module id_hazard_scoreboard #(
  parameter int NREG  = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  id_hazard_scoreboard_if.slave hz
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DSTALL = 2'b01,
    ST_FREEZE = 2'b10
  } haz_state_e;

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic            ex_ld_v_q;
  logic            ex_ld_v_d;
  logic [AW-1:0]   ex_ld_rd_q;
  logic [AW-1:0]   ex_ld_rd_d;
  haz_state_e      state_q;
  haz_state_e      state_d;

  logic ld_hz_rs;
  logic ld_hz_rt;
  logic br_hz_rs;
  logic br_hz_rt;
  logic hazard;
  logic stall_raw;
  logic issue;
  logic ld_set;
  logic flush_clr;

  // Per-operand load-use and branch-on-EX hazard detection.
  // A WB write to the operand is forwarded, so it masks the busy bit.
  always_comb begin
    ld_hz_rs = hz.ID_uses_rs && (hz.ID_RegRs != {AW{1'b0}}) && busy_q[hz.ID_RegRs]
               && !(hz.WB_RegWrite && (hz.WB_RegRd == hz.ID_RegRs));
    ld_hz_rt = hz.ID_uses_rt && (hz.ID_RegRt != {AW{1'b0}}) && busy_q[hz.ID_RegRt]
               && !(hz.WB_RegWrite && (hz.WB_RegRd == hz.ID_RegRt));
    br_hz_rs = hz.branch_or_jalr && hz.ID_uses_rs && hz.EX_RegWrite
               && (hz.EX_RegRd != {AW{1'b0}}) && (hz.EX_RegRd == hz.ID_RegRs);
    br_hz_rt = hz.branch_or_jalr && hz.ID_uses_rt && hz.EX_RegWrite
               && (hz.EX_RegRd != {AW{1'b0}}) && (hz.EX_RegRd == hz.ID_RegRt);
    hazard   = ld_hz_rs | ld_hz_rt | br_hz_rs | br_hz_rt;
  end

  // Ungated stall decision and the resulting issue / scoreboard-set strobes.
  always_comb begin
    stall_raw = hz.mem_wait | (hazard & ~hz.flush_EX);
    issue     = ~stall_raw & ~hz.mem_wait & ~hz.flush_EX;
    ld_set    = issue & hz.ID_MemRead & (hz.ID_RegRd != {AW{1'b0}});
    flush_clr = hz.flush_EX & ex_ld_v_q;
  end

  // Stall outputs respond in the same cycle; reset forces them low.
  assign hz.freeze    = hz.mem_wait & ~rst;
  assign hz.stall_ID  = stall_raw & ~rst;
  assign hz.bubble_EX = hazard & ~hz.mem_wait & ~hz.flush_EX & ~rst;
  assign hz.haz_state = state_q;

  // Scoreboard next state: a new load destination wins over a same-edge clear;
  // x0 is never busy.
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < NREG; r++) begin
      if (r == 0) begin
        busy_d[r] = 1'b0;
      end else if (ld_set && (hz.ID_RegRd == AW'(r))) begin
        busy_d[r] = 1'b1;
      end else if (hz.WB_RegWrite && (hz.WB_RegRd == AW'(r))) begin
        busy_d[r] = 1'b0;
      end else if (flush_clr && (ex_ld_rd_q == AW'(r))) begin
        busy_d[r] = 1'b0;
      end else begin
        busy_d[r] = busy_q[r];
      end
    end
  end

  // Track the load currently in EX so a flush can retract its busy bit.
  always_comb begin
    ex_ld_v_d  = ex_ld_v_q;
    ex_ld_rd_d = ex_ld_rd_q;
    if (ld_set) begin
      ex_ld_v_d  = 1'b1;
      ex_ld_rd_d = hz.ID_RegRd;
    end else if (flush_clr) begin
      ex_ld_v_d  = 1'b0;
    end else if (!hz.mem_wait) begin
      ex_ld_v_d  = 1'b0;
    end else begin
      ex_ld_v_d  = ex_ld_v_q;
    end
  end

  // Hazard FSM next state: memory wait dominates, then data stall.
  always_comb begin
    state_d = ST_RUN;
    if (hz.mem_wait) begin
      state_d = ST_FREEZE;
    end else if (hazard && !hz.flush_EX) begin
      state_d = ST_DSTALL;
    end else begin
      state_d = ST_RUN;
    end
  end

  // Scoreboard, in-flight load tracker and FSM state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= {NREG{1'b0}};
      ex_ld_v_q  <= 1'b0;
      ex_ld_rd_q <= {AW{1'b0}};
      state_q    <= ST_RUN;
    end else begin
      busy_q     <= busy_d;
      ex_ld_v_q  <= ex_ld_v_d;
      ex_ld_rd_q <= ex_ld_rd_d;
      state_q    <= state_d;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] freeze_cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  // Saturating counters of data-stall and freeze cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= {CNT_W{1'b0}};
      freeze_cnt_q <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_q  <= (state_d == ST_DSTALL) ? sat_inc(stall_cnt_q) : stall_cnt_q;
      freeze_cnt_q <= hz.mem_wait ? sat_inc(freeze_cnt_q) : freeze_cnt_q;
    end
  end

  assign hz.stall_cnt  = stall_cnt_q;
  assign hz.freeze_cnt = freeze_cnt_q;
`else
  assign hz.stall_cnt  = {CNT_W{1'b0}};
  assign hz.freeze_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_id_hazard_scoreboard
// Each cycle the bench drives stage inputs, pushes the expected same-cycle
// stall outputs and the expected post-edge state/counters onto queues, and
// pops/compares them when the DUT presents them. Directed scenarios are
// followed by a randomised run.
// ---------------------------------------------------------------------------
module tb_id_hazard_scoreboard;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_hazard_scoreboard_if #(.AW(5), .CNT_W(32)) hz_if ();

  id_hazard_scoreboard #(.NREG(32), .AW(5), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz_if)
  );

  int checks = 0;
  int errors = 0;

  typedef struct { logic stall; logic bubble; logic frz; } comb_exp_t;
  typedef struct { logic [1:0] st; logic [31:0] sc; logic [31:0] fc; } reg_exp_t;
  comb_exp_t comb_q[$];
  reg_exp_t  reg_q[$];

  // reference model state
  bit [31:0] m_busy;
  bit        m_exv;
  bit [4:0]  m_exrd;
  bit [1:0]  m_st;
  bit [31:0] m_scnt;
  bit [31:0] m_fcnt;

  int obs_stall;
  int obs_bubble;
  int obs_frz_st;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle();
    hz_if.ID_RegRs       = 5'd0;
    hz_if.ID_RegRt       = 5'd0;
    hz_if.ID_uses_rs     = 1'b0;
    hz_if.ID_uses_rt     = 1'b0;
    hz_if.ID_RegRd       = 5'd0;
    hz_if.ID_MemRead     = 1'b0;
    hz_if.branch_or_jalr = 1'b0;
    hz_if.EX_RegRd       = 5'd0;
    hz_if.EX_RegWrite    = 1'b0;
    hz_if.WB_RegRd       = 5'd0;
    hz_if.WB_RegWrite    = 1'b0;
    hz_if.mem_wait       = 1'b0;
    hz_if.flush_EX       = 1'b0;
  endtask

  function automatic bit opnd_hz(input bit [4:0] r, input bit u);
    bit ld;
    bit br;
    ld = u && (r != 5'd0) && m_busy[r] && !(hz_if.WB_RegWrite && (hz_if.WB_RegRd == r));
    br = hz_if.branch_or_jalr && u && hz_if.EX_RegWrite && (hz_if.EX_RegRd != 5'd0)
         && (hz_if.EX_RegRd == r);
    return ld | br;
  endfunction

  function automatic bit [31:0] sat(input bit [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // One clock cycle: predict, then compare comb outputs at negedge and
  // registered state just after the rising edge.
  task automatic step();
    comb_exp_t ce;
    reg_exp_t  re;
    bit haz, mw, fl, stall_u, issue, setb;
    mw  = hz_if.mem_wait;
    fl  = hz_if.flush_EX;
    haz = opnd_hz(hz_if.ID_RegRs, hz_if.ID_uses_rs) | opnd_hz(hz_if.ID_RegRt, hz_if.ID_uses_rt);
    stall_u = mw | (haz & !fl);
    if (rst) begin
      ce = '{1'b0, 1'b0, 1'b0};
    end else begin
      ce = '{stall_u, haz & !mw & !fl, mw};
    end
    comb_q.push_back(ce);

    if (rst) begin
      m_busy = 32'd0; m_exv = 1'b0; m_exrd = 5'd0; m_st = 2'b00;
      m_scnt = 32'd0; m_fcnt = 32'd0;
    end else begin
      issue = !stall_u && !mw && !fl;
      setb  = issue && hz_if.ID_MemRead && (hz_if.ID_RegRd != 5'd0);
      if (hz_if.WB_RegWrite) m_busy[hz_if.WB_RegRd] = 1'b0;
      if (fl && m_exv) m_busy[m_exrd] = 1'b0;
      if (setb) m_busy[hz_if.ID_RegRd] = 1'b1;
      m_busy[0] = 1'b0;
      if (setb) begin
        m_exv = 1'b1; m_exrd = hz_if.ID_RegRd;
      end else if (fl || !mw) begin
        m_exv = 1'b0;
      end
      m_st = mw ? 2'b10 : ((haz && !fl) ? 2'b01 : 2'b00);
      if (m_st == 2'b01) m_scnt = sat(m_scnt);
      if (mw) m_fcnt = sat(m_fcnt);
    end
    re.st = m_st;
`ifdef HAZ_PERF_CNT_EN
    re.sc = m_scnt;
    re.fc = m_fcnt;
`else
    re.sc = 32'd0;
    re.fc = 32'd0;
`endif
    reg_q.push_back(re);

    @(negedge clk);
    if (comb_q.size() == 0) begin
      check_val("comb_queue_empty", 32'd1, 32'd0);
    end else begin
      ce = comb_q.pop_front();
      check_val("stall_ID",  32'(hz_if.stall_ID),  32'(ce.stall));
      check_val("bubble_EX", 32'(hz_if.bubble_EX), 32'(ce.bubble));
      check_val("freeze",    32'(hz_if.freeze),    32'(ce.frz));
      if (hz_if.stall_ID === 1'b1)  obs_stall++;
      if (hz_if.bubble_EX === 1'b1) obs_bubble++;
    end

    @(posedge clk);
    #1;
    if (reg_q.size() == 0) begin
      check_val("reg_queue_empty", 32'd1, 32'd0);
    end else begin
      re = reg_q.pop_front();
      check_val("haz_state",  32'(hz_if.haz_state), 32'(re.st));
      check_val("stall_cnt",  hz_if.stall_cnt,      re.sc);
      check_val("freeze_cnt", hz_if.freeze_cnt,     re.fc);
      if (hz_if.haz_state === 2'b10) obs_frz_st++;
    end
  endtask

  task automatic clr_obs();
    obs_stall  = 0;
    obs_bubble = 0;
    obs_frz_st = 0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    m_busy = 32'd0; m_exv = 1'b0; m_exrd = 5'd0; m_st = 2'b00;
    m_scnt = 32'd0; m_fcnt = 32'd0;
    clr_obs();
    @(posedge clk);
    #1;
    step();
    check_val("reset_state", 32'(hz_if.haz_state), 32'd0);
    rst = 1'b0;

    // load-use: lw x5 then consumer of x5 -> two stall cycles
    idle(); hz_if.ID_MemRead = 1'b1; hz_if.ID_RegRd = 5'd5; step();
    idle(); hz_if.ID_uses_rs = 1'b1; hz_if.ID_RegRs = 5'd5; hz_if.ID_RegRd = 5'd6;
    clr_obs(); step(); step();
    hz_if.WB_RegWrite = 1'b1; hz_if.WB_RegRd = 5'd5; step();
    check_val("t1_stall_cycles",  32'(obs_stall),  32'd2);
    check_val("t1_bubble_cycles", 32'(obs_bubble), 32'd2);
`ifdef HAZ_PERF_CNT_EN
    check_val("t1_stall_cnt", hz_if.stall_cnt, 32'd2);
`endif

    // branch on EX result -> one stall; producer moved on -> none
    idle(); hz_if.branch_or_jalr = 1'b1; hz_if.ID_uses_rs = 1'b1; hz_if.ID_RegRs = 5'd7;
    hz_if.EX_RegWrite = 1'b1; hz_if.EX_RegRd = 5'd7;
    clr_obs(); step();
    hz_if.EX_RegWrite = 1'b0; step();
    check_val("t2_branch_stall", 32'(obs_stall), 32'd1);

    // mem_wait during load-use: three freeze cycles, no bubbles during them
    idle(); hz_if.ID_MemRead = 1'b1; hz_if.ID_RegRd = 5'd8; step();
    idle(); hz_if.ID_uses_rt = 1'b1; hz_if.ID_RegRt = 5'd8; hz_if.mem_wait = 1'b1;
    clr_obs(); step(); step(); step();
    hz_if.mem_wait = 1'b0; step(); step();
    hz_if.WB_RegWrite = 1'b1; hz_if.WB_RegRd = 5'd8; step();
    check_val("t3_freeze_states", 32'(obs_frz_st), 32'd3);
    check_val("t3_stall_cycles",  32'(obs_stall),  32'd5);
    check_val("t3_bubble_cycles", 32'(obs_bubble), 32'd2);
`ifdef HAZ_PERF_CNT_EN
    check_val("t3_freeze_cnt", hz_if.freeze_cnt, 32'd3);
`endif

    // killed load: flush clears busy[9], consumer never stalls
    idle(); hz_if.ID_MemRead = 1'b1; hz_if.ID_RegRd = 5'd9; step();
    idle(); hz_if.ID_uses_rs = 1'b1; hz_if.ID_RegRs = 5'd9; hz_if.flush_EX = 1'b1;
    clr_obs(); step();
    hz_if.flush_EX = 1'b0; step(); step();
    check_val("t4_flush_no_stall", 32'(obs_stall), 32'd0);

    // x0 never busy; unused operand never stalls
    idle(); hz_if.ID_MemRead = 1'b1; hz_if.ID_RegRd = 5'd0; step();
    idle(); hz_if.ID_uses_rs = 1'b1; hz_if.ID_uses_rt = 1'b1;
    clr_obs(); step();
    idle(); hz_if.ID_MemRead = 1'b1; hz_if.ID_RegRd = 5'd10; step();
    idle(); hz_if.ID_RegRs = 5'd10; hz_if.ID_RegRt = 5'd10; step(); step();
    check_val("t5_no_stall", 32'(obs_stall), 32'd0);
    idle(); hz_if.WB_RegWrite = 1'b1; hz_if.WB_RegRd = 5'd10; step();

    // reset in the middle of a data stall
    idle(); hz_if.ID_MemRead = 1'b1; hz_if.ID_RegRd = 5'd11; step();
    idle(); hz_if.ID_uses_rs = 1'b1; hz_if.ID_RegRs = 5'd11; step();
    check_val("t6_in_dstall", 32'(hz_if.haz_state), 32'd1);
    rst = 1'b1; clr_obs(); step();
    check_val("t6_rst_outputs", 32'(obs_stall), 32'd0);
    check_val("t6_rst_state",   32'(hz_if.haz_state), 32'd0);
`ifdef HAZ_PERF_CNT_EN
    check_val("t6_rst_stall_cnt", hz_if.stall_cnt, 32'd0);
`endif
    rst = 1'b0; clr_obs(); step(); step();
    check_val("t6_busy_cleared", 32'(obs_stall), 32'd0);

    // randomised traffic with small register range to force collisions
    for (int i = 0; i < 400; i++) begin
      rst                  = ($urandom_range(0, 49) == 0);
      hz_if.ID_RegRs       = 5'($urandom_range(0, 3));
      hz_if.ID_RegRt       = 5'($urandom_range(0, 3));
      hz_if.ID_uses_rs     = 1'($urandom_range(0, 1));
      hz_if.ID_uses_rt     = 1'($urandom_range(0, 1));
      hz_if.ID_RegRd       = 5'($urandom_range(0, 3));
      hz_if.ID_MemRead     = ($urandom_range(0, 2) == 0);
      hz_if.branch_or_jalr = ($urandom_range(0, 3) == 0);
      hz_if.EX_RegRd       = 5'($urandom_range(0, 3));
      hz_if.EX_RegWrite    = 1'($urandom_range(0, 1));
      hz_if.WB_RegRd       = 5'($urandom_range(0, 3));
      hz_if.WB_RegWrite    = ($urandom_range(0, 2) == 0);
      hz_if.mem_wait       = ($urandom_range(0, 5) == 0);
      hz_if.flush_EX       = ($urandom_range(0, 7) == 0);
      step();
    end
    rst = 1'b0;
    idle();
    check_val("queues_drained", 32'(comb_q.size() + reg_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
